// File: rtl/dsp_mac_cell_param.sv
// One FIOS multiply-accumulate cell: P = W + Z + A*B with valid-tagged A/B and M pipelines.
// Cells chain through PCIN_i/PCOUT_o to form a Montgomery datapath row.
module dsp_mac_cell_param #(
  parameter int OP_WIDTH    = 17,
  parameter int ACC_WIDTH   = 48,
  parameter int ABREG       = 1,
  parameter int MREG        = 1,
  parameter int CREG        = 1,
  parameter int P_OUT_WIDTH = 2 * OP_WIDTH
) (
  input  logic                   clock_i,
  input  logic                   reset_i,
  input  logic                   valid_i,
  input  logic [2:0]             mode_i,
  input  logic [OP_WIDTH-1:0]    A_i,
  input  logic [OP_WIDTH-1:0]    B_i,
  input  logic [ACC_WIDTH-1:0]   C_i,
  input  logic                   CREG_en_i,
  input  logic [ACC_WIDTH-1:0]   PCIN_i,
  output logic                   valid_o,
  output logic [ACC_WIDTH-1:0]   PCOUT_o,
  output logic [P_OUT_WIDTH-1:0] P_o,
  output logic                   carry_o
);

  localparam int PW = 2 * OP_WIDTH;

  if (ABREG < 0 || ABREG > 2) begin : g_bad_abreg
    $error("dsp_mac_cell_param: ABREG must be 0..2");
  end
  if (MREG < 0 || MREG > 1) begin : g_bad_mreg
    $error("dsp_mac_cell_param: MREG must be 0..1");
  end
  if (CREG < 0 || CREG > 1) begin : g_bad_creg
    $error("dsp_mac_cell_param: CREG must be 0..1");
  end
  if (PW >= ACC_WIDTH) begin : g_bad_width
    $error("dsp_mac_cell_param: 2*OP_WIDTH must be below ACC_WIDTH");
  end
  if (P_OUT_WIDTH < 1 || P_OUT_WIDTH > ACC_WIDTH) begin : g_bad_pout
    $error("dsp_mac_cell_param: P_OUT_WIDTH must be 1..ACC_WIDTH");
  end

  logic [OP_WIDTH-1:0] a_s;
  logic [OP_WIDTH-1:0] b_s;
  logic [2:0]          mode_ab;
  logic                vld_ab;

  // Mode and valid ride alongside A/B so the Z/W select always matches its own product.
  if (ABREG == 0) begin : g_ab_bypass
    assign a_s     = A_i;
    assign b_s     = B_i;
    assign mode_ab = mode_i;
    assign vld_ab  = valid_i;
  end else begin : g_ab_pipe
    logic [OP_WIDTH-1:0] a_q    [ABREG];
    logic [OP_WIDTH-1:0] b_q    [ABREG];
    logic [2:0]          mode_q [ABREG];
    logic                vld_q  [ABREG];

    always_ff @(posedge clock_i) begin
      if (reset_i) begin
        for (int i = 0; i < ABREG; i++) begin
          a_q[i]    <= '0;
          b_q[i]    <= '0;
          mode_q[i] <= '0;
          vld_q[i]  <= 1'b0;
        end
      end else begin
        a_q[0]    <= A_i;
        b_q[0]    <= B_i;
        mode_q[0] <= mode_i;
        vld_q[0]  <= valid_i;
        for (int i = 1; i < ABREG; i++) begin
          a_q[i]    <= a_q[i-1];
          b_q[i]    <= b_q[i-1];
          mode_q[i] <= mode_q[i-1];
          vld_q[i]  <= vld_q[i-1];
        end
      end
    end

    assign a_s     = a_q[ABREG-1];
    assign b_s     = b_q[ABREG-1];
    assign mode_ab = mode_q[ABREG-1];
    assign vld_ab  = vld_q[ABREG-1];
  end

  logic [PW-1:0] m_c;
  logic [PW-1:0] m_s;
  logic [2:0]    mode_p;
  logic          vld_p;

  assign m_c = {{OP_WIDTH{1'b0}}, a_s} * {{OP_WIDTH{1'b0}}, b_s};

  if (MREG == 0) begin : g_m_bypass
    assign m_s    = m_c;
    assign mode_p = mode_ab;
    assign vld_p  = vld_ab;
  end else begin : g_m_pipe
    logic [PW-1:0] m_q;
    logic [2:0]    mode_q;
    logic          vld_q;

    always_ff @(posedge clock_i) begin
      if (reset_i) begin
        m_q    <= '0;
        mode_q <= '0;
        vld_q  <= 1'b0;
      end else begin
        m_q    <= m_c;
        mode_q <= mode_ab;
        vld_q  <= vld_ab;
      end
    end

    assign m_s    = m_q;
    assign mode_p = mode_q;
    assign vld_p  = vld_q;
  end

  logic [ACC_WIDTH-1:0] c_val;

  // The C register is not part of the beat pipeline: whatever it holds when a beat reaches P is used.
  if (CREG == 1) begin : g_creg
    logic [ACC_WIDTH-1:0] c_q;

    always_ff @(posedge clock_i) begin
      if (reset_i) begin
        c_q <= '0;
      end else if (CREG_en_i) begin
        c_q <= C_i;
      end
    end

    assign c_val = c_q;
  end else begin : g_creg_bypass
    assign c_val = C_i;
  end

  logic [ACC_WIDTH-1:0] p_q;
  logic [ACC_WIDTH-1:0] p_d;
  logic                 carry_q;
  logic                 carry_d;
  logic                 valid_q;
  logic [ACC_WIDTH-1:0] z_val;
  logic [ACC_WIDTH-1:0] w_val;
  logic [ACC_WIDTH:0]   sum;

  always_comb begin
    z_val = '0;
    case (mode_p[1:0])
      2'b01:   z_val = PCIN_i;
      2'b10:   z_val = p_q;
      2'b11:   z_val = PCIN_i >> OP_WIDTH;
      default: z_val = '0;
    endcase
    w_val = mode_p[2] ? c_val : '0;
    // Bit ACC_WIDTH of a modulo-2^(ACC_WIDTH+1) sum equals bit ACC_WIDTH of the full three-way sum.
    sum = {1'b0, w_val} + {1'b0, z_val} + {{(ACC_WIDTH + 1 - PW){1'b0}}, m_s};
    p_d     = p_q;
    carry_d = carry_q;
    if (vld_p) begin
      p_d     = sum[ACC_WIDTH-1:0];
      carry_d = sum[ACC_WIDTH];
    end
  end

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      p_q     <= '0;
      carry_q <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      p_q     <= p_d;
      carry_q <= carry_d;
      valid_q <= vld_p;
    end
  end

  assign valid_o = valid_q;
  assign PCOUT_o = p_q;
  assign P_o     = p_q[P_OUT_WIDTH-1:0];
  assign carry_o = carry_q;

endmodule

// File: tb/tb_dsp_mac_cell_param.sv
// Directed bench for dsp_mac_cell_param: default cell plus ABREG=0/MREG=0 and ABREG=2 latency variants.
module tb_dsp_mac_cell_param;

  logic        clk = 1'b0;
  logic        rst;
  logic        vld;
  logic [2:0]  mode;
  logic [16:0] a;
  logic [16:0] b;
  logic [47:0] c;
  logic        cen;
  logic [47:0] pcin;

  logic        v1, v0, v2;
  logic [47:0] pc1, pc0, pc2;
  logic [33:0] p1, p0, p2;
  logic        cy1, cy0, cy2;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  dsp_mac_cell_param u_dut (
    .clock_i(clk), .reset_i(rst), .valid_i(vld), .mode_i(mode), .A_i(a), .B_i(b),
    .C_i(c), .CREG_en_i(cen), .PCIN_i(pcin),
    .valid_o(v1), .PCOUT_o(pc1), .P_o(p1), .carry_o(cy1)
  );

  dsp_mac_cell_param #(.ABREG(0), .MREG(0)) u_dut_l1 (
    .clock_i(clk), .reset_i(rst), .valid_i(vld), .mode_i(mode), .A_i(a), .B_i(b),
    .C_i(c), .CREG_en_i(cen), .PCIN_i(pcin),
    .valid_o(v0), .PCOUT_o(pc0), .P_o(p0), .carry_o(cy0)
  );

  dsp_mac_cell_param #(.ABREG(2)) u_dut_l4 (
    .clock_i(clk), .reset_i(rst), .valid_i(vld), .mode_i(mode), .A_i(a), .B_i(b),
    .C_i(c), .CREG_en_i(cen), .PCIN_i(pcin),
    .valid_o(v2), .PCOUT_o(pc2), .P_o(p2), .carry_o(cy2)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic beat(input logic v, input logic [2:0] m, input logic [16:0] av, input logic [16:0] bv);
    vld  = v;
    mode = m;
    a    = av;
    b    = bv;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    beat(1'b1, 3'b010, 17'd9, 17'd9);
    c = 48'd5; cen = 1'b1; pcin = 48'hFFFF;
    repeat (3) tick();
    n_cmp++;
    if (v1 !== 1'b0) begin n_err++; $display("FAIL reset_valid: got %b want 0", v1); end
    n_cmp++;
    if (pc1 !== 48'd0) begin n_err++; $display("FAIL reset_pcout: got %h want 0", pc1); end
    n_cmp++;
    if (cy1 !== 1'b0) begin n_err++; $display("FAIL reset_carry: got %b want 0", cy1); end
    n_cmp++;
    if ({v0, v2, pc0, pc2} !== '0) begin n_err++; $display("FAIL reset_variants: got %b%b %h %h want 0", v0, v2, pc0, pc2); end
    beat(1'b0, 3'b000, 17'd0, 17'd0);
    c = 48'd0; cen = 1'b0; pcin = 48'd0;
    rst = 1'b0;
    tick();
  endtask

  task automatic test_default();
    beat(1'b1, 3'b000, 17'd3, 17'd5);
    tick();
    beat(1'b0, 3'b000, 17'd0, 17'd0);
    n_cmp++;
    if (v1 !== 1'b0) begin n_err++; $display("FAIL default_e1_valid: got %b want 0", v1); end
    tick();
    n_cmp++;
    if (v1 !== 1'b0) begin n_err++; $display("FAIL default_e2_valid: got %b want 0", v1); end
    tick();
    n_cmp++;
    if (v1 !== 1'b1) begin n_err++; $display("FAIL default_e3_valid: got %b want 1", v1); end
    n_cmp++;
    if (p1 !== 34'd15) begin n_err++; $display("FAIL default_p: got %h want f", p1); end
    n_cmp++;
    if (cy1 !== 1'b0) begin n_err++; $display("FAIL default_carry: got %b want 0", cy1); end
    tick();
    n_cmp++;
    if (v1 !== 1'b0) begin n_err++; $display("FAIL default_pulse_width: got %b want 0", v1); end
    n_cmp++;
    if (p1 !== 34'd15) begin n_err++; $display("FAIL default_hold: got %h want f", p1); end
  endtask

  task automatic test_accumulate();
    logic [6:0] seen;
    logic [6:0] exp_seen;
    exp_seen = 7'b0111100;
    seen = '0;
    for (int i = 0; i < 7; i++) begin
      if (i < 4) beat(1'b1, (i == 0) ? 3'b000 : 3'b010, 17'h1FFFF, 17'h1FFFF);
      else       beat(1'b0, 3'b000, 17'd0, 17'd0);
      tick();
      seen[i] = v1;
    end
    n_cmp++;
    if (seen !== exp_seen) begin n_err++; $display("FAIL accum_valid_train: got %b want %b", seen, exp_seen); end
    n_cmp++;
    if (pc1 !== 48'hFFFF00004) begin n_err++; $display("FAIL accum_pcout: got %h want ffff00004", pc1); end
  endtask

  task automatic test_cascade_shift();
    pcin = 48'h300000000;
    c = 48'd1; cen = 1'b1;
    beat(1'b1, 3'b011, 17'd0, 17'd0);
    tick();
    beat(1'b0, 3'b000, 17'd0, 17'd0);
    repeat (2) tick();
    n_cmp++;
    if (pc1 !== 48'h18000) begin n_err++; $display("FAIL shift_z: got %h want 18000", pc1); end
    beat(1'b1, 3'b111, 17'd0, 17'd0);
    tick();
    beat(1'b0, 3'b000, 17'd0, 17'd0);
    repeat (2) tick();
    n_cmp++;
    if (pc1 !== 48'h18001) begin n_err++; $display("FAIL shift_zw: got %h want 18001", pc1); end
    pcin = 48'd0; cen = 1'b0;
  endtask

  task automatic test_c_hold();
    c = 48'd7; cen = 1'b1;
    tick();
    c = 48'd9; cen = 1'b0;
    beat(1'b1, 3'b100, 17'd0, 17'd0);
    tick();
    beat(1'b0, 3'b000, 17'd0, 17'd0);
    repeat (2) tick();
    n_cmp++;
    if (pc1 !== 48'd7) begin n_err++; $display("FAIL c_hold: got %h want 7", pc1); end
    c = 48'd0;
  endtask

  task automatic test_wrap();
    pcin = 48'hFFFF_FFFF_FFFF;
    beat(1'b1, 3'b001, 17'd1, 17'd1);
    tick();
    beat(1'b1, 3'b000, 17'd0, 17'd0);
    tick();
    beat(1'b0, 3'b000, 17'd0, 17'd0);
    tick();
    n_cmp++;
    if (pc1 !== 48'd0) begin n_err++; $display("FAIL wrap_p: got %h want 0", pc1); end
    n_cmp++;
    if (cy1 !== 1'b1) begin n_err++; $display("FAIL wrap_carry: got %b want 1", cy1); end
    tick();
    n_cmp++;
    if (cy1 !== 1'b0 || v1 !== 1'b1) begin n_err++; $display("FAIL wrap_next_carry: got carry %b valid %b want 0 1", cy1, v1); end
    pcin = 48'd0;
    tick();
  endtask

  task automatic test_reset_flush();
    int pulses;
    beat(1'b1, 3'b000, 17'd3, 17'd5);
    tick();
    beat(1'b0, 3'b000, 17'd0, 17'd0);
    repeat (3) tick();
    n_cmp++;
    if (pc1 !== 48'd15) begin n_err++; $display("FAIL flush_pre: got %h want f", pc1); end
    beat(1'b1, 3'b010, 17'd4, 17'd4);
    tick();
    tick();
    beat(1'b0, 3'b000, 17'd0, 17'd0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    pulses = 0;
    for (int i = 0; i < 6; i++) begin
      if (v1 === 1'b1) pulses++;
      tick();
    end
    n_cmp++;
    if (pulses !== 0) begin n_err++; $display("FAIL flush_no_valid: got %0d pulses want 0", pulses); end
    n_cmp++;
    if (pc1 !== 48'd0) begin n_err++; $display("FAIL flush_p: got %h want 0", pc1); end
    beat(1'b1, 3'b010, 17'd1, 17'd1);
    tick();
    beat(1'b0, 3'b000, 17'd0, 17'd0);
    repeat (2) tick();
    n_cmp++;
    if (pc1 !== 48'd1) begin n_err++; $display("FAIL flush_accum_from_zero: got %h want 1", pc1); end
  endtask

  task automatic test_sweep();
    int lat0, lat1, lat2;
    lat0 = 0; lat1 = 0; lat2 = 0;
    beat(1'b1, 3'b000, 17'd3, 17'd5);
    for (int e = 1; e <= 8; e++) begin
      tick();
      beat(1'b0, 3'b000, 17'd0, 17'd0);
      if (v0 === 1'b1 && lat0 == 0) lat0 = e;
      if (v1 === 1'b1 && lat1 == 0) lat1 = e;
      if (v2 === 1'b1 && lat2 == 0) lat2 = e;
    end
    n_cmp++;
    if (lat0 !== 1) begin n_err++; $display("FAIL sweep_lat_ab0_m0: got %0d want 1", lat0); end
    n_cmp++;
    if (lat1 !== 3) begin n_err++; $display("FAIL sweep_lat_default: got %0d want 3", lat1); end
    n_cmp++;
    if (lat2 !== 4) begin n_err++; $display("FAIL sweep_lat_ab2: got %0d want 4", lat2); end
    n_cmp++;
    if (p0 !== 34'd15 || p2 !== 34'd15) begin n_err++; $display("FAIL sweep_p: got %h %h want f f", p0, p2); end
  endtask

  initial begin
    rst = 1'b1;
    beat(1'b0, 3'b000, 17'd0, 17'd0);
    c = '0; cen = 1'b0; pcin = '0;
    test_reset();
    test_default();
    test_accumulate();
    test_cascade_shift();
    test_c_hold();
    test_wrap();
    test_reset_flush();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
    test_sweep();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
